// File: rtl/counter_5bit_ctrl_if.sv
// Handshake and counter-control bundle between the fill/drain controller and its surroundings.
// The slave modport is the controller's view; master is the upstream/downstream/datapath side.
interface counter_5bit_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] cnt;
    logic             down_done;
    logic             cntU;
    logic             cntD;
    logic             rst5;
    logic             busy;
    logic             done;
    logic             ovf;

    modport slave (
        input  start, abort, in_valid, in_last, out_ready, cnt, down_done,
        output in_ready, out_valid, cntU, cntD, rst5, busy, done, ovf
    );

    modport master (
        output start, abort, in_valid, in_last, out_ready, cnt, down_done,
        input  in_ready, out_valid, cntU, cntD, rst5, busy, done, ovf
    );
endinterface

// File: rtl/counter_5bit_ctrl.sv
// Fill/drain sequencer driving an external up/down counter; handshakes are combinational.
// state | meaning: IDLE wait start | CLR clear counter | FILL count items in | DRAIN count items out | DONE end pulse
module counter_5bit_ctrl #(
    parameter int CNT_W   = 5,
    parameter int CNT_MAX = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_5bit_ctrl_if.slave     ctl
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FILL  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(CNT_MAX);

    state_t state_q, state_d;
    logic   ovf_q, ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ovf_d         = ovf_q;
        ctl.in_ready  = 1'b0;
        ctl.out_valid = 1'b0;
        ctl.cntU      = 1'b0;
        ctl.cntD      = 1'b0;
        ctl.rst5      = 1'b0;
        ctl.done      = 1'b0;
        ctl.busy      = (state_q != S_IDLE);
        ctl.ovf       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (ctl.start) state_d = S_CLR;
            end
            S_CLR: begin
                ctl.rst5 = 1'b1;
                ovf_d    = 1'b0;
                state_d  = S_FILL;
            end
            S_FILL: begin
                if (ctl.abort) begin
                    ctl.rst5 = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    ctl.in_ready = (ctl.cnt != FULL_LVL);
                    if (ctl.in_valid && ctl.in_ready) begin
                        ctl.cntU = 1'b1;
                        if (ctl.in_last) state_d = S_DRAIN;
                    end
                    // An item offered at full is refused and flagged, even when it is the last one.
                    if (ctl.in_valid && !ctl.in_ready) ovf_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (ctl.abort) begin
                    ctl.rst5 = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    ctl.out_valid = ~ctl.down_done;
                    ctl.cntD      = ctl.out_valid && ctl.out_ready;
                    if (ctl.down_done) state_d = S_DONE;
                end
            end
            S_DONE: begin
                ctl.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_counter_5bit_ctrl.sv
// Directed bench for counter_5bit_ctrl with a behavioural counter datapath and an expectation queue.
// Each step pushes the expected output vector, then pops and compares it once outputs settle.
module tb_counter_5bit_ctrl;
    logic clk;
    logic rst;

    counter_5bit_ctrl_if #(.CNT_W(5)) bus ();

    counter_5bit_ctrl #(.CNT_W(5), .CNT_MAX(31)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter datapath as the controller expects to see it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           bus.cnt <= 5'd0;
        else if (bus.rst5) bus.cnt <= 5'd0;
        else if (bus.cntU) bus.cnt <= bus.cnt + 5'd1;
        else if (bus.cntD) bus.cnt <= bus.cnt - 5'd1;
    end
    assign bus.down_done = (bus.cnt == 5'd0);

    typedef struct {
        string       tag;
        logic [12:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    // {cnt, busy, done, in_ready, out_valid, cntU, cntD, rst5, ovf}
    function automatic logic [12:0] ev(int c, logic b, logic d, logic ir, logic ov,
                                       logic u, logic dn, logic r5, logic of);
        return {5'(c), b, d, ir, ov, u, dn, r5, of};
    endfunction

    task automatic now(string tag, logic [12:0] e);
        sb_t         ent;
        logic [12:0] obs;
        ent.tag = tag;
        ent.exp = e;
        sb_q.push_back(ent);
        #1;
        obs = {bus.cnt, bus.busy, bus.done, bus.in_ready, bus.out_valid,
               bus.cntU, bus.cntD, bus.rst5, bus.ovf};
        ent = sb_q.pop_front();
        n_cmp++;
        assert (obs === ent.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", ent.tag, obs, ent.exp);
        end
    endtask

    task automatic cyc(string tag, logic [12:0] e);
        now(tag, e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        now("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        // Three items in, three out.
        bus.start = 1'b1;
        cyc("t1_idle_start", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b0;
        cyc("t1_clr", ev(0, 1, 0, 0, 0, 0, 0, 1, 0));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) cyc("t1_fill", ev(i, 1, 0, 1, 0, 1, 0, 0, 0));
        bus.in_last = 1'b1;
        cyc("t1_fill_last", ev(2, 1, 0, 1, 0, 1, 0, 0, 0));
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 3; k > 0; k--) cyc("t1_drain", ev(k, 1, 0, 0, 1, 0, 1, 0, 0));
        cyc("t1_drain_zero", ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
        bus.out_ready = 1'b0;
        cyc("t1_done", ev(0, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc("t1_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Four items with start held throughout; drain with toggling out_ready.
        bus.start = 1'b1;
        cyc("t2_idle_start", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("t2_clr", ev(0, 1, 0, 0, 0, 0, 0, 1, 0));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) cyc("t2_fill", ev(i, 1, 0, 1, 0, 1, 0, 0, 0));
        bus.in_last = 1'b1;
        cyc("t2_fill_last", ev(3, 1, 0, 1, 0, 1, 0, 0, 0));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int j = 0; j < 7; j++) begin
            bus.out_ready = ((j % 2) == 0);
            cyc("t2_drain_toggle", ev(4 - (j + 1) / 2, 1, 0, 0, 1, 0, bus.out_ready, 0, 0));
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        cyc("t2_drain_zero", ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("t2_done", ev(0, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc("t2_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Abort in DRAIN at cnt=7.
        bus.start = 1'b1;
        cyc("t3_idle_start", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b0;
        cyc("t3_clr", ev(0, 1, 0, 0, 0, 0, 0, 1, 0));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) cyc("t3_fill", ev(i, 1, 0, 1, 0, 1, 0, 0, 0));
        bus.in_last = 1'b1;
        cyc("t3_fill_last", ev(6, 1, 0, 1, 0, 1, 0, 0, 0));
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        bus.abort     = 1'b1;
        cyc("t3_abort_drain", ev(7, 1, 0, 0, 0, 0, 0, 1, 0));
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        cyc("t3_after_abort", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Fill to full, then offer a last item at full.
        bus.start = 1'b1;
        cyc("t4_idle_start", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b0;
        cyc("t4_clr", ev(0, 1, 0, 0, 0, 0, 0, 1, 0));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 31; i++) cyc("t4_fill", ev(i, 1, 0, 1, 0, 1, 0, 0, 0));
        bus.in_last = 1'b1;
        cyc("t4_full_last", ev(31, 1, 0, 0, 0, 0, 0, 0, 0));
        bus.in_last = 1'b0;
        cyc("t4_full_ovf", ev(31, 1, 0, 0, 0, 0, 0, 0, 1));
        bus.in_valid = 1'b0;
        bus.abort    = 1'b1;
        cyc("t4_abort_fill", ev(31, 1, 0, 0, 0, 0, 0, 1, 1));
        bus.abort = 1'b0;
        cyc("t4_idle_ovf_sticky", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // New sequence clears ovf; async reset mid-FILL at cnt=10.
        bus.start = 1'b1;
        cyc("t5_idle_start", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
        bus.start = 1'b0;
        cyc("t5_clr", ev(0, 1, 0, 0, 0, 0, 0, 1, 1));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) cyc("t5_fill", ev(i, 1, 0, 1, 0, 1, 0, 0, 0));
        now("t5_pre_rst", ev(10, 1, 0, 1, 0, 1, 0, 0, 0));
        rst = 1'b1;
        now("t5_async_rst", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        cyc("t5_idle_after_rst", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
